// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage with 8-entry register file and RAW scoreboard
//
// Purpose:
//    Accepts 16-bit instructions over a valid/ready handshake. Source operands
//    are read from an internal 8 x N register file, with a bypass from the
//    writeback port. The stage presents the operands, a one-hot ALU opcode and
//    the destination register in a single registered output slot. A
//    per-register pending bit stalls issue on read-after-write hazards.
//
// Ports:
//    clk, rst                  clock, asynchronous active-high reset
//    in_valid, in_ready, instr instruction handshake; instr = {op,rd,rs1,rs2,3'bx}
//    out_valid, out_ready      output slot handshake toward the ALU
//    a, b, opcode, rd          slot contents: operands, one-hot op, destination
//    wb_en, wb_rd, wb_data     ALU result writeback into the register file
//    illegal                   one-cycle pulse after an illegal op is accepted

module decode_issue #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [15:0]  instr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] a,
   output logic [N-1:0] b,
   output logic [13:0]  opcode,
   output logic [2:0]   rd,
   input  logic         wb_en,
   input  logic [2:0]   wb_rd,
   input  logic [N-1:0] wb_data,
   output logic         illegal
);

   // Instruction fields
   logic [3:0] f_op;
   logic [2:0] f_rd;
   logic [2:0] f_rs1;
   logic [2:0] f_rs2;
   logic       unused_bits;

   assign f_op        = instr[15:12];
   assign f_rd        = instr[11:9];
   assign f_rs1       = instr[8:6];
   assign f_rs2       = instr[5:3];
   assign unused_bits = ^instr[2:0];

   // State
   logic [N-1:0] regs_q [8];
   logic [N-1:0] regs_d [8];
   logic [7:0]   pend_q, pend_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [13:0]  opcode_q, opcode_d;
   logic [2:0]   rd_q, rd_d;
   logic         illegal_q, illegal_d;

   // Hazard / handshake
   logic         byp1, byp2;
   logic         haz;
   logic         legal;
   logic         accept;
   logic [N-1:0] opnd1, opnd2;

   always_comb begin
      byp1 = wb_en && (wb_rd == f_rs1);
      byp2 = wb_en && (wb_rd == f_rs2);

      // A pending source is fine if its result is arriving this very cycle.
      haz = ((f_rs1 != 3'd0) && pend_q[f_rs1] && !byp1) ||
            ((f_rs2 != 3'd0) && pend_q[f_rs2] && !byp2);

      in_ready = (!out_valid_q || out_ready) && !haz;
      legal    = (f_op < 4'd14);
      accept   = in_valid && in_ready;

      // r0 is hardwired to zero, even when a writeback targets it.
      if (f_rs1 == 3'd0) begin
         opnd1 = '0;
      end else if (byp1) begin
         opnd1 = wb_data;
      end else begin
         opnd1 = regs_q[f_rs1];
      end

      if (f_rs2 == 3'd0) begin
         opnd2 = '0;
      end else if (byp2) begin
         opnd2 = wb_data;
      end else begin
         opnd2 = regs_q[f_rs2];
      end
   end

   // Next-state
   always_comb begin
      regs_d      = regs_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      opcode_d    = opcode_q;
      rd_d        = rd_q;
      illegal_d   = 1'b0;

      if (wb_en && (wb_rd != 3'd0)) begin
         regs_d[wb_rd] = wb_data;
      end

      // Clear first so a same-cycle set of the same bit wins: the newly
      // issued write is the one still outstanding.
      if (wb_en) begin
         pend_d[wb_rd] = 1'b0;
      end

      if (accept && legal) begin
         out_valid_d = 1'b1;
         a_d         = opnd1;
         b_d         = opnd2;
         opcode_d    = 14'(1) << f_op;
         rd_d        = f_rd;
         if (f_rd != 3'd0) begin
            pend_d[f_rd] = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Illegal ops are dropped; the slot and scoreboard are left alone.
      if (accept && !legal) begin
         illegal_d = 1'b1;
      end

      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         opcode_q    <= '0;
         rd_q        <= '0;
         illegal_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         opcode_q    <= opcode_d;
         rd_q        <= rd_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign a         = a_q;
   assign b         = b_q;
   assign opcode    = opcode_q;
   assign rd        = rd_q;
   assign illegal   = illegal_q;

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage directly upstream of the execute ALU. Accepts 16-bit instructions over a valid/ready handshake, reads two source operands from an internal 8-entry register file, and presents `a`, `b`, the 14-bit one-hot ALU `opcode` and the destination register in a registered output slot. ALU results return through a writeback port into the register file. A per-register pending scoreboard stalls issue on read-after-write hazards.

## Interface
- `N`, default 32: operand and register width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  stage accepts `instr` this cycle; combinational.
- `instr`  in  16  instruction word:
  - [15:12] op; values 0–13 legal, 14–15 illegal.
  - [11:9] rd.
  - [8:6] rs1.
  - [5:3] rs2.
  - [2:0] ignored.
- `out_valid`  out  1  output slot holds an issued instruction.
- `out_ready`  in  1  ALU consumes the slot this cycle.
- `a`  out  N  operand 1, the rs1 value.
- `b`  out  N  operand 2, the rs2 value.
- `opcode`  out  14  one-hot; bit[op] set.
- `rd`  out  3  destination register, passed to writeback.
- `wb_en`  in  1  write `wb_data` into register `wb_rd`.
- `wb_rd`  in  3  writeback destination.
- `wb_data`  in  N  writeback value, the ALU result.
- `illegal`  out  1  one-cycle pulse after an illegal op is accepted.

## Operation
- Register file: 8 × N entries.
  - r0 reads as 0.
  - Writes to r0 are ignored.
- Scoreboard: `pend[7:0]`; `pend[0]` is always 0.
- Hazard: `haz = (rs1≠0 && pend[rs1] && !byp1) || (rs2≠0 && pend[rs2] && !byp2)`.
  - `bypK` means `wb_en && wb_rd==rsK` this cycle.
- `in_ready = (!out_valid || out_ready) && !haz`.
  - Depends on `instr` when `in_valid` is high.
- Operand read on accept:
  - If `bypK`, the operand takes `wb_data` (writeback-to-read bypass).
  - Otherwise it takes the register file value.
  - r0 is always 0, even when bypassed.
- Accept (`in_valid && in_ready`), legal op:
  - Output slot loads `a`, `b`, `opcode = 1<<op`, `rd`.
  - `out_valid` set to 1.
  - If rd≠0, `pend[rd]` set.
- Accept, illegal op:
  - Instruction is dropped: slot not loaded, scoreboard untouched.
  - `out_valid` cleared if it was being consumed.
  - `illegal` = 1 for exactly the next cycle.
- Slot consumed (`out_valid && out_ready`) with no new legal accept: `out_valid` ← 0, data outputs hold.
- Writeback: `wb_en` writes `wb_data` to the register file and clears `pend[wb_rd]`.
- Same-cycle set and clear of the same `pend` bit: set wins (the newer write is outstanding).
- WAW is not checked: in-order single-slot ALU guarantees ordering.

## Timing
- Reset (async, immediate):
  - All registers 0 and `pend` = 0.
  - `out_valid`, `a`, `b`, `opcode`, `rd`, `illegal` all 0.
  - An in-flight slot is discarded.
- Latency: instruction accepted at edge k is presented with `out_valid` = 1 after edge k.
  - Sustained throughput: 1/cycle with `out_ready` held high and no hazards.
- Output stability: while `out_valid && !out_ready`, `a`/`b`/`opcode`/`rd` are held stable and `in_ready` = 0.
- Writeback at edge k is visible to a register file read in cycle k+1.
  - Same-cycle visibility comes only via the bypass.
- `illegal` never asserts together with a change of slot contents from that same instruction.

## Test plan
- Reset mid-stream:
  - Stimulus: `out_valid` = 1, `pend[3]` set, then assert `rst`.
  - Required: `out_valid`/`opcode`/`illegal` go to 0 immediately; after release, an instruction reading r3 issues without stall.
- Back-to-back independent issue:
  - Stimulus: wb r1=5, r2=7; issue op 0 (rd4, rs1 r1, rs2 r2) then op 13 (rd5, rs1 r2, rs2 r1).
  - Required: consecutive cycles give `a=5,b=7,opcode=0x0001,rd=4`, then `a=7,b=5,opcode=0x2000,rd=5`.
- RAW stall then bypass:
  - Stimulus: issue rd3; next instruction reads r3.
  - Required: `in_ready` = 0 until `wb_en` with `wb_rd=3`, `wb_data=0x2A`; in that cycle `in_ready` = 1 and the issued `a` = 0x2A.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1.
  - Required: outputs stable, `in_ready` = 0; on `out_ready` = 1, the slot is consumed and the next instruction is loaded the same edge.
- Illegal op:
  - Stimulus: op = 14, rd = 2.
  - Required: `illegal` pulses for 1 cycle, `out_valid` stays 0, `pend[2]` stays 0.
- r0 semantics:
  - Stimulus: wb r0 = 0xFF; issue rd0 reading r0, r0.
  - Required: `a=b=0`, no stall, `pend` = 0.
